// File: rtl/lock_ctrl_if.sv
// Key event channel from the keypad debouncer/decoder into lock_ctrl.
// master drives a one-cycle key_valid pulse with the decoded key code.
interface lock_ctrl_if;
    logic       key_valid;
    logic [3:0] key_val;

    modport master (output key_valid, output key_val);
    modport slave  (input  key_valid, input  key_val);
endinterface

// File: rtl/lock_ctrl.sv
// Keypad lock sequencer: 4-digit entry, code check, retry lockout, auto-relock.
// Define LOCK_PROG_EN to enable the PROG state and the writable passcode.
module lock_ctrl #(
    parameter logic [15:0] DEFAULT_CODE  = 16'h1234,
    parameter int          MAX_TRIES     = 3,
    parameter logic [15:0] LOCKOUT_TICKS = 16'd500,
    parameter logic [15:0] UNLOCK_TICKS  = 16'd250
) (
    input  logic        clk,
    input  logic        rst,
    lock_ctrl_if.slave  key,
    input  logic        tick,
    output logic [3:0]  disp0,
    output logic [3:0]  disp1,
    output logic [3:0]  disp2,
    output logic [3:0]  disp3,
    output logic [3:0]  disp_en,
    output logic        unlocked,
    output logic        alarm,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_LOCKED  = 3'd0,
        S_CHECK   = 3'd1,
        S_OPEN    = 3'd2,
        S_PROG    = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    localparam int FW = $clog2(MAX_TRIES + 1);
    localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_TRIES);
    // A zero-length timer would never expire, so it is stretched to one tick.
    localparam logic [15:0] LOCK_T = (LOCKOUT_TICKS == 16'd0) ? 16'd1 : LOCKOUT_TICKS;
    localparam logic [15:0] OPEN_T = (UNLOCK_TICKS == 16'd0) ? 16'd1 : UNLOCK_TICKS;

    state_t        cur;
    state_t        nxt;
    logic [3:0]    dig   [4];
    logic [3:0]    dig_n [4];
    logic [3:0]    en;
    logic [3:0]    en_n;
    logic [2:0]    count;
    logic [2:0]    count_n;
    logic [FW-1:0] fail_cnt;
    logic [FW-1:0] fail_n;
    logic [FW-1:0] fail_inc;
    logic [15:0]   timer;
    logic [15:0]   timer_n;
    logic [15:0]   code;
    logic          unlocked_n;
    logic          alarm_n;
    logic          clr;

    logic k_digit;
    logic k_enter;
    logic k_clear;
    logic entry;
    logic expire;
    logic match;

    assign k_digit = key.key_valid && (key.key_val <= 4'd9);
    assign k_enter = key.key_valid && (key.key_val == 4'hA);
    assign k_clear = key.key_valid && (key.key_val == 4'hB);

    // Digits are only collected while waiting for a code or a new code.
    assign entry  = ((cur == S_LOCKED) || (cur == S_PROG))
                    && k_digit && (count < 3'd4);
    // Timer never goes below zero: the tick from 1 (or a stray 0) ends the wait.
    assign expire = tick && (timer <= 16'd1);
    assign match  = (count == 3'd4)
                    && ({dig[0], dig[1], dig[2], dig[3]} == code);
    assign fail_inc = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + FW'(1);

`ifdef LOCK_PROG_EN
    logic       k_prog;
    logic [15:0] code_n;

    assign k_prog = key.key_valid && (key.key_val == 4'hC);

    // Writable passcode; reset always restores the default.
    always_ff @(posedge clk) begin
        if (rst) code <= DEFAULT_CODE;
        else     code <= code_n;
    end
`else
    assign code = DEFAULT_CODE;
`endif

    // State and datapath registers, including the registered flag outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur      <= S_LOCKED;
            for (int i = 0; i < 4; i++) dig[i] <= 4'd0;
            en       <= 4'd0;
            count    <= 3'd0;
            fail_cnt <= '0;
            timer    <= 16'd0;
            unlocked <= 1'b0;
            alarm    <= 1'b0;
        end else begin
            cur      <= nxt;
            for (int i = 0; i < 4; i++) dig[i] <= dig_n[i];
            en       <= en_n;
            count    <= count_n;
            fail_cnt <= fail_n;
            timer    <= timer_n;
            unlocked <= unlocked_n;
            alarm    <= alarm_n;
        end
    end

    // Next-state and next-datapath decision for the current state and inputs.
    always_comb begin
        nxt     = cur;
        for (int i = 0; i < 4; i++) dig_n[i] = dig[i];
        en_n    = en;
        count_n = count;
        fail_n  = fail_cnt;
        timer_n = timer;
        clr     = 1'b0;
`ifdef LOCK_PROG_EN
        code_n  = code;
`endif
        if (entry) begin
            dig_n[count[1:0]] = key.key_val;
            en_n[count[1:0]]  = 1'b1;
            count_n           = count + 3'd1;
        end
        case (cur)
            S_LOCKED: begin
                if (k_clear)      clr = 1'b1;
                else if (k_enter) nxt = S_CHECK;
            end
            S_CHECK: begin
                clr = 1'b1;
                if (match) begin
                    nxt     = S_OPEN;
                    fail_n  = '0;
                    timer_n = OPEN_T;
                end else begin
                    fail_n = fail_inc;
                    if (fail_inc == FAIL_MAX) begin
                        nxt     = S_LOCKOUT;
                        timer_n = LOCK_T;
                    end else begin
                        nxt = S_LOCKED;
                    end
                end
            end
            S_OPEN: begin
                // Expiry wins over a key arriving in the same cycle.
                if (expire) begin
                    nxt     = S_LOCKED;
                    timer_n = 16'd0;
                end else begin
                    if (tick) timer_n = timer - 16'd1;
                    if (k_clear) begin
                        nxt     = S_LOCKED;
                        timer_n = 16'd0;
                    end
`ifdef LOCK_PROG_EN
                    else if (k_prog) begin
                        nxt = S_PROG;
                    end
`endif
                end
            end
`ifdef LOCK_PROG_EN
            S_PROG: begin
                // Leaving PROG always empties the buffer for the next entry.
                if (k_enter && (count == 3'd4)) begin
                    code_n = {dig[0], dig[1], dig[2], dig[3]};
                    nxt    = S_LOCKED;
                    clr    = 1'b1;
                end else if (k_clear) begin
                    clr = 1'b1;
                    if (count == 3'd0) nxt = S_LOCKED;
                end
            end
`endif
            S_LOCKOUT: begin
                if (expire) begin
                    nxt     = S_LOCKED;
                    timer_n = 16'd0;
                    fail_n  = '0;
                end else if (tick) begin
                    timer_n = timer - 16'd1;
                end
            end
            default: begin
                nxt = S_LOCKED;
                clr = 1'b1;
            end
        endcase
        if (clr) begin
            for (int i = 0; i < 4; i++) dig_n[i] = 4'd0;
            en_n    = 4'd0;
            count_n = 3'd0;
        end
    end

    // Flag outputs decoded from the upcoming state so they register with it.
    always_comb begin
        unlocked_n = (nxt == S_OPEN) || (nxt == S_PROG);
        alarm_n    = (nxt == S_LOCKOUT);
    end

    assign disp0   = dig[0];
    assign disp1   = dig[1];
    assign disp2   = dig[2];
    assign disp3   = dig[3];
    assign disp_en = en;
    assign state   = cur;

endmodule

// File: doc/lock_ctrl.md
# lock_ctrl

Sequencing controller for the keypad digital lock. It consumes debounced single-cycle key events (decoded 4-bit key values) and collects a 4-digit entry. It compares the entry against a stored passcode and drives the unlock, alarm and four display-digit registers that feed the seven-segment `disp_ctrl` instances. A retry counter, lockout timer and auto-relock timer are all paced by an external tick strobe.

## Interface
- `DEFAULT_CODE`, 16'h1234: passcode after reset, 4 BCD nibbles; digit 0 is `[15:12]`.
- `MAX_TRIES`, 3: consecutive failed attempts that trigger lockout; must be ≥1.
- `LOCKOUT_TICKS`, 16'd500: tick count spent in LOCKOUT.
- `UNLOCK_TICKS`, 16'd250: tick count before OPEN auto-relocks.
- `clk`  in  1  system clock; the single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `key_valid`  in  1  one-cycle pulse: a key press is present on `key_val`.
- `key_val`  in  4  key code: 0x0–0x9 digit, 0xA ENTER, 0xB CLEAR, 0xC PROGRAM, 0xD–0xF ignored.
- `tick`  in  1  one-cycle timebase strobe.
- `disp0`..`disp3`  out  4 each  entered digit per display position (0 = first entered).
- `disp_en`  out  4  bit i high = position i holds a valid digit.
- `unlocked`  out  1  high in OPEN and PROG.
- `alarm`  out  1  high in LOCKOUT.
- `state`  out  3  LOCKED=0, CHECK=1, OPEN=2, PROG=3, LOCKOUT=4.

## Operation
- **Reset values.** On reset: `state`=LOCKED, `disp0`..`disp3`=0, `disp_en`=0, `count`=0, `unlocked`=0, `alarm`=0, `fail_cnt`=0, `timer`=0, stored code=`DEFAULT_CODE`. Reset mid-operation aborts everything, including PROG, and restores `DEFAULT_CODE`.
- **Digit entry (LOCKED and PROG).**
  - A digit key with `count`<4 writes `disp[count]`, sets `disp_en[count]`, and increments `count`.
  - A digit with `count`==4 is dropped.
  - CLEAR zeroes the buffer, `disp_en` and `count`.
- **LOCKED.**
  - ENTER → CHECK, regardless of `count`.
  - PROGRAM and ignored codes have no effect.
- **CHECK.** One cycle, no key is accepted.
  - Match means `count`==4 and all four digits equal the stored code.
  - On match → OPEN: `fail_cnt`=0, `timer`=`UNLOCK_TICKS`.
  - On mismatch: `fail_cnt`+1. If the new value equals `MAX_TRIES` → LOCKOUT with `timer`=`LOCKOUT_TICKS`; otherwise → LOCKED.
  - Both exits clear the buffer, `disp_en` and `count`.
- **OPEN.**
  - `tick` decrements `timer`; reaching 0 → LOCKED.
  - CLEAR → LOCKED immediately.
  - PROGRAM → PROG (see Configuration).
  - Digits and ENTER are ignored.
- **PROG.**
  - ENTER with `count`==4 stores the buffer as the new code → LOCKED.
  - ENTER with `count`<4 is ignored.
  - CLEAR with `count`==0 aborts → LOCKED, code unchanged. CLEAR with `count`>0 only clears the buffer.
  - No timeout.
- **LOCKOUT.**
  - All keys are dropped.
  - `tick` decrements `timer`; reaching 0 → LOCKED with `fail_cnt`=0.
- **Timer and counters.**
  - `timer` is 16-bit and never wraps below 0.
  - A timer parameter of 0 is treated as 1 tick.
  - `fail_cnt` saturates; it is sized as `$clog2(MAX_TRIES+1)` bits.

## Timing
- **Output registration.** All outputs are registered. A key event sampled at edge N is visible on outputs after edge N.
- **ENTER latency.** ENTER sampled at edge N gives `state`=CHECK after N. `unlocked` or `alarm` updates after N+1.
- **Timer expiry.** The `tick` that takes `timer` from 1 to 0 at edge N produces the state change after N.
- **Simultaneous `key_valid` and `tick`.**
  - OPEN: if the tick expires the timer, expiry wins and the key is dropped. Otherwise both take effect.
  - LOCKED and PROG: `tick` is a don't-care.
- **Key during CHECK.** A `key_valid` during CHECK is lost; there is no buffering.

## Configuration
- Macro: `LOCK_PROG_EN`.
- **Defined.**
  - PROG state and the writable code register exist as described.
- **Undefined.**
  - PROGRAM is ignored in OPEN.
  - The code is the constant `DEFAULT_CODE`.
  - State 3 is unreachable.

## Test plan
- **Correct code.** Reset; keys 1,2,3,4,A → `state` 1 then 2, `unlocked`=1 two cycles after the A edge, `disp_en`=0. Then 250 ticks → `state`=0, `unlocked`=0.
- **Lockout.** 1,2,3,5,A three times → `fail_cnt` 1,2, then `state`=4 and `alarm`=1. Keys during lockout change nothing. After 500 ticks → `state`=0, `alarm`=0. Keys 1,2,3,4,A then unlock.
- **Entry bounds and short ENTER.** Digits 7,8,9,6,5 → `disp0..3`=7,8,9,6, `disp_en`=4'hF. Then B → `disp_en`=0. Then 1,2,A → counted as a failure, `fail_cnt`=1.
- **Reprogram (`LOCK_PROG_EN`).** Unlock, C, 9,8,7,6,A → `state`=0. Then 1,2,3,4,A fails and 9,8,7,6,A unlocks. Assert `rst` → 1,2,3,4 unlocks again.
- **Expiry beats key.** In OPEN with `timer`=1, assert `tick` and `key_val`=C together → `state`=0, not 3.
- **Reset mid-entry.** Digits 1,2 entered, `rst` for one cycle → all outputs at reset values.
